// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: read-select encodings,
// default data width and the debounce counter width helper.
package gpio_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        RDSEL_IN1  = 2'b00,
        RDSEL_IN2  = 2'b01,
        RDSEL_OUT1 = 2'b10,
        RDSEL_OUT2 = 2'b11
    } rdsel_e;

    // Bits needed to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gpio_if.sv
// CPU-side bus between the GPIO address decoder / store path and the
// peripheral: write strobes, read select, write data and read data.
interface gpio_if
    import gpio_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         we1;
    logic         we2;
    logic [1:0]   rdsel;
    logic [W-1:0] wd;
    logic [W-1:0] rd;

    modport master (output we1, we2, rdsel, wd, input rd);
    modport slave  (input we1, we2, rdsel, wd, output rd);
endinterface

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser followed by a whole-word debouncer: the output
// follows the synchronised input once it has held one value for DB_CYCLES edges.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_pin,
    output logic [W-1:0] o_deb
);
    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

    logic [W-1:0]  r_sync1;
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_cand;
    logic [W-1:0]  r_deb;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_step;

    // Count this edge: a new candidate starts at 1, a repeated one extends the run.
    always_comb begin
        w_cnt_step = (r_s == r_cand) ? r_cnt + CW'(1) : CW'(1);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_s     <= '0;
            r_cand  <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_s     <= r_sync1;
            r_cand  <= r_s;
            if (r_s == r_deb) begin
                r_cnt <= '0;
            end else if (w_cnt_step == CNT_MAX) begin
                r_deb <= r_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_step;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/gpio.sv
// Memory-mapped GPIO: two writable output registers, two debounced input
// words, and a combinational read mux over the four registered words.
module gpio
    import gpio_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    gpio_if.slave        bus,
    input  logic [W-1:0] gpi1,
    input  logic [W-1:0] gpi2,
    output logic [W-1:0] gpo1,
    output logic [W-1:0] gpo2
);
    logic [W-1:0] r_gpo1;
    logic [W-1:0] r_gpo2;
    logic [W-1:0] w_deb1;
    logic [W-1:0] w_deb2;

    // Both strobes high is not expected from the decoder; both registers load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpo1 <= '0;
            r_gpo2 <= '0;
        end else begin
            if (bus.we1) r_gpo1 <= bus.wd;
            if (bus.we2) r_gpo2 <= bus.wd;
        end
    end

    gpio_debounce #(.W(W), .DB_CYCLES(DB_CYCLES)) u_deb1 (
        .clk   (clk),
        .rst   (rst),
        .i_pin (gpi1),
        .o_deb (w_deb1)
    );

    gpio_debounce #(.W(W), .DB_CYCLES(DB_CYCLES)) u_deb2 (
        .clk   (clk),
        .rst   (rst),
        .i_pin (gpi2),
        .o_deb (w_deb2)
    );

    // NOTE: default assigned first so the mux can never infer a latch.
    always_comb begin
        bus.rd = '0;
        case (bus.rdsel)
            RDSEL_IN1:  bus.rd = w_deb1;
            RDSEL_IN2:  bus.rd = w_deb2;
            RDSEL_OUT1: bus.rd = r_gpo1;
            RDSEL_OUT2: bus.rd = r_gpo2;
            default:    bus.rd = '0;
        endcase
    end

    assign gpo1 = r_gpo1;
    assign gpo2 = r_gpo2;

endmodule

// File: tb/tb_gpio.sv
// Self-checking bench for gpio (W=32, DB_CYCLES=4): directed scenarios plus a
// randomized run checked against a pin-history reference model.
module tb_gpio;
    import gpio_pkg::*;

    localparam int W  = 32;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gpi1;
    logic [W-1:0] gpi2;
    logic [W-1:0] gpo1;
    logic [W-1:0] gpo2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_if #(.W(W)) bus ();

    gpio #(.W(W), .DB_CYCLES(DB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gpi1 (gpi1),
        .gpi2 (gpi2),
        .gpo1 (gpo1),
        .gpo2 (gpo2)
    );

    // Reference model: output registers plus, per input word, the pin values
    // sampled at the most recent DB+2 edges (index 0 = this edge).
    logic [W-1:0] m_gpo1;
    logic [W-1:0] m_gpo2;
    logic [W-1:0] m_deb [2];
    logic [W-1:0] m_ph  [2][DB+2];

    task automatic model_edge();
        logic stable;
        if (rst) begin
            m_gpo1 = '0;
            m_gpo2 = '0;
            for (int w = 0; w < 2; w++) begin
                m_deb[w] = '0;
                for (int i = 0; i < DB + 2; i++) m_ph[w][i] = '0;
            end
        end else begin
            if (bus.we1) m_gpo1 = bus.wd;
            if (bus.we2) m_gpo2 = bus.wd;
            for (int w = 0; w < 2; w++) begin
                for (int i = DB + 1; i > 0; i--) m_ph[w][i] = m_ph[w][i-1];
                m_ph[w][0] = (w == 0) ? gpi1 : gpi2;
                // Pin seen two edges ago is what the debouncer sees now;
                // it has to agree across the last DB edges.
                stable = 1'b1;
                for (int i = 3; i < DB + 2; i++)
                    if (m_ph[w][i] != m_ph[w][2]) stable = 1'b0;
                if (stable && m_ph[w][2] != m_deb[w]) m_deb[w] = m_ph[w][2];
            end
        end
    endtask

    function automatic logic [W-1:0] m_rd(input int sel);
        case (sel)
            0:       return m_deb[0];
            1:       return m_deb[1];
            2:       return m_gpo1;
            default: return m_gpo2;
        endcase
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_at(input int sel, output logic [W-1:0] v);
        bus.rdsel = 2'(sel);
        #1;
        v = bus.rd;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        rst = 1'b1;
        bus.we1 = 1'b0; bus.we2 = 1'b0; bus.wd = '0; bus.rdsel = 2'b00;
        gpi1 = 32'hFFFF_FFFF; gpi2 = '0;
        step();
        step();
        total++;
        if (gpo1 !== '0) begin bad++; $display("FAIL reset_gpo1: got %h expected 0", gpo1); end
        total++;
        if (gpo2 !== '0) begin bad++; $display("FAIL reset_gpo2: got %h expected 0", gpo2); end
        for (int s = 0; s < 4; s++) begin
            rd_at(s, v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL reset_rd sel=%0d: got %h expected 0", s, v); end
        end
        gpi1 = '0;
        rst  = 1'b0;
    endtask

    task automatic test_write();
        logic [W-1:0] v;
        bus.we1 = 1'b1; bus.wd = 32'hDEAD_BEEF;
        step();
        bus.we1 = 1'b0;
        rd_at(2, v);
        total++;
        if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write1_latency: got %h expected deadbeef", v); end
        bus.we2 = 1'b1; bus.wd = 32'h1234_5678;
        step();
        bus.we2 = 1'b0;
        bus.wd  = '0;
        step();
        rd_at(2, v);
        total++;
        if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_hold_out1: got %h expected deadbeef", v); end
        rd_at(3, v);
        total++;
        if (v !== 32'h1234_5678) begin bad++; $display("FAIL write_hold_out2: got %h expected 12345678", v); end
        total++;
        if (gpo1 !== 32'hDEAD_BEEF || gpo2 !== 32'h1234_5678) begin
            bad++; $display("FAIL write_pins: got %h/%h expected deadbeef/12345678", gpo1, gpo2);
        end
    endtask

    task automatic test_debounce_latency();
        logic [W-1:0] v;
        gpi1 = 32'h0000_00A5;
        for (int e = 0; e <= 4; e++) begin
            step();
            rd_at(0, v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL deb_early edge k+%0d: got %h expected 0", e, v); end
        end
        step();
        rd_at(0, v);
        total++;
        if (v !== 32'h0000_00A5) begin bad++; $display("FAIL deb_update edge k+5: got %h expected 000000a5", v); end
    endtask

    task automatic test_glitch();
        logic [W-1:0] v;
        gpi2 = 32'h0000_0001;
        for (int e = 0; e < 9; e++) begin
            if (e == 3) gpi2 = '0;
            step();
            rd_at(1, v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL glitch_rd cycle %0d: got %h expected 0", e, v); end
        end
        total++;
        if (dut.u_deb2.r_cnt !== 3'd0) begin bad++; $display("FAIL glitch_cnt: got %0d expected 0", dut.u_deb2.r_cnt); end
    endtask

    task automatic test_bounce();
        logic [W-1:0] v;
        gpi1 = '0;
        for (int e = 0; e < DB + 3; e++) step();
        rd_at(0, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL bounce_settle0: got %h expected 0", v); end
        for (int t = 0; t < 2; t++) begin
            gpi1 = (t == 0) ? 32'd3 : 32'd0;
            for (int e = 0; e < 2; e++) begin
                step();
                rd_at(0, v);
                total++;
                if (v !== '0) begin bad++; $display("FAIL bounce_toggle: got %h expected 0", v); end
            end
        end
        gpi1 = 32'd3;
        for (int e = 0; e <= DB; e++) begin
            step();
            rd_at(0, v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL bounce_early edge k+%0d: got %h expected 0", e, v); end
        end
        step();
        rd_at(0, v);
        total++;
        if (v !== 32'd3) begin bad++; $display("FAIL bounce_final: got %h expected 3", v); end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] v;
        gpi1 = 32'hF;
        for (int e = 0; e <= 4; e++) step();
        total++;
        if (dut.u_deb1.r_cnt !== 3'd3) begin bad++; $display("FAIL midcnt_pre: got %0d expected 3", dut.u_deb1.r_cnt); end
        rst = 1'b1;
        bus.we1 = 1'b1; bus.wd = 32'hCAFE_F00D;
        step();
        rst = 1'b0;
        bus.we1 = 1'b0;
        rd_at(0, v);
        total++;
        if (v !== '0) begin bad++; $display("FAIL midcnt_deb_cleared: got %h expected 0", v); end
        total++;
        if (gpo1 !== '0 || dut.u_deb1.r_cnt !== 3'd0) begin
            bad++; $display("FAIL midcnt_regs_cleared: got gpo1=%h cnt=%0d expected 0/0", gpo1, dut.u_deb1.r_cnt);
        end
        for (int e = 1; e <= DB + 1; e++) begin
            step();
            rd_at(0, v);
            total++;
            if (v !== '0) begin bad++; $display("FAIL midcnt_early edge r+%0d: got %h expected 0", e, v); end
        end
        step();
        rd_at(0, v);
        total++;
        if (v !== 32'hF) begin bad++; $display("FAIL midcnt_relatch edge r+%0d: got %h expected f", DB + 2, v); end
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(3))
            0:       return '0;
            1:       return 32'h1;
            2:       return 32'hF0;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [W-1:0] v;
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(63) == 0);
            bus.we1 = ($urandom_range(3) == 0);
            bus.we2 = ($urandom_range(3) == 0);
            bus.wd  = W'($urandom);
            if ($urandom_range(3) == 0) gpi1 = pick_val();
            if ($urandom_range(3) == 0) gpi2 = pick_val();
            step();
            for (int s = 0; s < 4; s++) begin
                rd_at(s, v);
                total++;
                if (v !== m_rd(s)) begin
                    bad++; $display("FAIL random_rd cycle %0d sel=%0d: got %h expected %h", c, s, v, m_rd(s));
                end
            end
            total++;
            if (gpo1 !== m_gpo1 || gpo2 !== m_gpo2) begin
                bad++; $display("FAIL random_gpo cycle %0d: got %h/%h expected %h/%h", c, gpo1, gpo2, m_gpo1, m_gpo2);
            end
        end
        rst = 1'b0;
        bus.we1 = 1'b0;
        bus.we2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_debounce_latency();
        test_glitch();
        test_bounce();
        test_reset_mid_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
